granule_bit_scheduler: RTL and testbench
========================================

// Module: granule_bit_scheduler
// PURPOSE
//  Sequences one frame's main-data bit stream through the scalefactor parser, then the Huffman decoder,
//  once per granule/channel: gr0ch0, gr0ch1, gr1ch0, gr1ch1 (ch1 steps only when stereo).
//  Bounds each slot by part2_3_length; routes serial bits; pulses the per-slot side-info strobe.
//  Sits between the main-data bit reservoir and the sf_parser / Huffman datapath.
// PARAMETERS
//  LEN_W   12  width of part2_3_length and of the slot bit counter
//  NGR     2   granules per frame (MPEG-1 layer III)
// PORTS
//  clk             in   1          system clock
//  rst             in   1          synchronous active-high reset
//  si_valid        in   1          1-cycle strobe: frame side info below is valid
//  stereo          in   1          0 = mono (ch0 only), 1 = two channels
//  part2_3_length  in   [1:0][1:0][LEN_W-1:0]  per [gr][ch] bit budget; sampled on si_valid
//  axiid           in   1          main-data serial bit
//  axiiv           in   1          bit valid
//  axiir           out  1          bit accepted this cycle when axiiv & axiir
//  gr              out  1          granule of active slot (selects side info into sf_parser)
//  ch              out  1          channel of active slot
//  sf_si_valid     out  1          1-cycle start strobe to sf_parser
//  sf_axiid/sf_axiiv out 1/1       bit stream to sf_parser
//  sf_done         in   1          sf_parser finished (its axiov)
//  hf_start        out  1          1-cycle start strobe to Huffman decoder
//  hf_axiid/hf_axiiv out 1/1       bit stream to Huffman decoder
//  hf_last         out  1          qualifies the final hf bit of the slot
//  frame_done      out  1          1-cycle pulse after the last slot ends
//  err             out  1          sticky; cleared by rst or next accepted si_valid
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0. Counters 0. Latched lengths 0.
//  - States:
//    - IDLE: on si_valid, latch lengths and stereo; slot = gr0ch0; clear err; go LOAD.
//    - LOAD:
//      - len==0 -> NEXT; no sf/hf strobes.
//      - else drive sf_si_valid=1 for this one cycle; cnt<=0; go SF_RUN.
//    - SF_RUN: axiir = ~sf_done (combinational). Each accepted bit -> sf_axiid/sf_axiiv same cycle; cnt++.
//      - sf_done -> HF_START if cnt<len, else NEXT.
//      - cnt==len with no sf_done -> set err; go NEXT (slot aborted).
//    - HF_START: hf_start=1 for one cycle, no bits accepted -> HF_RUN.
//    - HF_RUN: axiir=1. Accepted bits -> hf_axiid/hf_axiiv; cnt++.
//      - hf_last=1 on the bit that makes cnt==len; that cycle -> NEXT.
//    - NEXT: advance slot (ch1 only if stereo) -> LOAD. After gr1 last channel, pulse frame_done -> IDLE.
//  - axiir=0 in IDLE, LOAD, HF_START and NEXT. No bit is ever dropped or duplicated.
//  - Each slot consumes exactly len bits unless aborted. Abort keeps unconsumed bits; upstream realigns.
//  - sf_done outside SF_RUN is ignored.
//  - si_valid outside IDLE is ignored and sets err.
//  - gr/ch stay stable from LOAD through NEXT of each slot.
//  - Counter compares at full LEN_W width; len=4095 is legal, no wrap.
//  - rst mid-frame: immediate IDLE; partial slot discarded; no frame_done.
// CONFIGURATION
//  GRANULE_STATS_EN defined:
//    - extra output sf_bits [3:0][LEN_W-1:0], indexed {gr,ch}.
//    - each entry latches cnt at sf_done; zeroed at si_valid and rst.
//  Undefined: port absent, no extra logic. Core behaviour identical.
// TESTING
//  - Mono; len gr0=100, gr1=50; sf_done after 20 / 0 bits:
//    -> sf 20 + hf 80, then hf 50 only; hf_last on bits 100 and 50; one frame_done; err=0.
//  - Stereo; all len=30; sf_done after 10 each -> slots in order 00,01,10,11; 120 bits total; frame_done once.
//  - len[0][0]=0 -> no sf_si_valid/hf_start for that slot; next slot's LOAD follows directly.
//  - len=40, sf_done never -> err=1 after bit 40; next slot proceeds; err holds until next si_valid.
//  - sf_done exactly on cnt==len=25 -> no hf_start; slot closes with zero hf bits.
//  - Gaps: axiiv duty 1/5 (sf_parser bench rate) -> counts unchanged.
//  - rst mid HF_RUN -> outputs 0, IDLE next cycle; new si_valid runs a clean frame.

Source files
------------

// File: rtl/granule_bit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : granule_bit_scheduler
// Description : Steers one frame of main-data serial bits first into the
//               scalefactor parser and then into the Huffman decoder, once per
//               granule/channel slot (gr0ch0, gr0ch1, gr1ch0, gr1ch1; the ch1
//               slots are visited only for stereo). Each slot is bounded by
//               its part2_3_length. The scheduler raises the per-slot start
//               strobes and flags slots whose scalefactor parse overruns.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   LEN_W  width of part2_3_length and of the slot bit counter
//   NGR    granules per frame
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   si_valid_i                1-cycle frame side-info strobe
//   stereo_i                  0 = mono, 1 = two channels
//   part2_3_length_i[gr][ch]  per-slot bit budget, sampled on si_valid_i
//   axiid_i/axiiv_i/axiir_o   upstream serial bit stream and its ready
//   gr_o, ch_o                granule / channel of the active slot
//   sf_si_valid_o             start strobe to the scalefactor parser
//   sf_axiid_o/sf_axiiv_o     bit stream to the scalefactor parser
//   sf_done_i                 scalefactor parser finished
//   hf_start_o                start strobe to the Huffman decoder
//   hf_axiid_o/hf_axiiv_o     bit stream to the Huffman decoder
//   hf_last_o                 marks the final Huffman bit of the slot
//   frame_done_o              1-cycle pulse once the last slot has ended
//   err_o                     sticky error flag
// Build option
//   GRANULE_STATS_EN : adds sf_bits_o[{gr,ch}], the scalefactor bit count
//                      captured when sf_done_i is seen for each slot.
// ============================================================================
module granule_bit_scheduler #(
    parameter int LEN_W = 12,
    parameter int NGR   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         si_valid_i,
    input  logic                         stereo_i,
    input  logic [1:0][1:0][LEN_W-1:0]   part2_3_length_i,
    input  logic                         axiid_i,
    input  logic                         axiiv_i,
    output logic                         axiir_o,
    output logic                         gr_o,
    output logic                         ch_o,
    output logic                         sf_si_valid_o,
    output logic                         sf_axiid_o,
    output logic                         sf_axiiv_o,
    input  logic                         sf_done_i,
    output logic                         hf_start_o,
    output logic                         hf_axiid_o,
    output logic                         hf_axiiv_o,
    output logic                         hf_last_o,
    output logic                         frame_done_o,
    output logic                         err_o
`ifdef GRANULE_STATS_EN
    ,
    output logic [3:0][LEN_W-1:0]        sf_bits_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SF_RUN   = 3'd2,
        S_HF_START = 3'd3,
        S_HF_RUN   = 3'd4,
        S_NEXT     = 3'd5
    } state_t;

    localparam logic LAST_GR = 1'(NGR - 1);

    state_t                       state_q;
    logic [1:0][1:0][LEN_W-1:0]   len_q;
    logic                         stereo_q;
    logic                         gr_q;
    logic                         ch_q;
    logic [LEN_W-1:0]             cnt_q;
    logic                         err_q;
    logic                         sf_si_valid_q;
    logic                         hf_start_q;
    logic                         frame_done_q;

    logic [LEN_W-1:0]             w_len;
    logic [LEN_W-1:0]             w_cnt_inc;
    logic                         w_cnt_lt_len;
    logic                         w_sf_take;
    logic                         w_in_hf;
    logic                         w_nxt_gr;

    assign w_len        = len_q[gr_q][ch_q];
    assign w_cnt_inc    = cnt_q + 1'b1;
    assign w_cnt_lt_len = (cnt_q < w_len);
    assign w_nxt_gr     = gr_q + 1'b1;

    // The scalefactor path stops taking bits once the budget is used up, so
    // the cycle spent checking for a late sf_done never swallows an extra bit.
    assign w_sf_take = (state_q == S_SF_RUN) && !sf_done_i && w_cnt_lt_len;
    assign w_in_hf   = (state_q == S_HF_RUN);

    assign axiir_o    = w_sf_take | w_in_hf;
    assign sf_axiiv_o = w_sf_take & axiiv_i;
    assign sf_axiid_o = w_sf_take & axiiv_i & axiid_i;
    assign hf_axiiv_o = w_in_hf & axiiv_i;
    assign hf_axiid_o = w_in_hf & axiiv_i & axiid_i;
    assign hf_last_o  = hf_axiiv_o && (w_cnt_inc == w_len);

    assign gr_o          = gr_q;
    assign ch_o          = ch_q;
    assign sf_si_valid_o = sf_si_valid_q;
    assign hf_start_o    = hf_start_q;
    assign frame_done_o  = frame_done_q;
    assign err_o         = err_q;

`ifdef GRANULE_STATS_EN
    logic [3:0][LEN_W-1:0] sf_bits_q;
    assign sf_bits_o = sf_bits_q;
`endif

    // Strobes are registered: each is set on the transition into the state
    // in which it must be visible, so it is high for exactly that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            stereo_q      <= 1'b0;
            gr_q          <= 1'b0;
            ch_q          <= 1'b0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            sf_si_valid_q <= 1'b0;
            hf_start_q    <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef GRANULE_STATS_EN
            sf_bits_q     <= '0;
`endif
        end else begin
            sf_si_valid_q <= 1'b0;
            hf_start_q    <= 1'b0;
            frame_done_q  <= 1'b0;

            // A new frame header while one is still in flight is a protocol error.
            if (si_valid_i && (state_q != S_IDLE)) begin
                err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (si_valid_i) begin
                        len_q         <= part2_3_length_i;
                        stereo_q      <= stereo_i;
                        gr_q          <= 1'b0;
                        ch_q          <= 1'b0;
                        err_q         <= 1'b0;
                        sf_si_valid_q <= (part2_3_length_i[0][0] != '0);
`ifdef GRANULE_STATS_EN
                        sf_bits_q     <= '0;
`endif
                        state_q       <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= (w_len == '0) ? S_NEXT : S_SF_RUN;
                end

                S_SF_RUN: begin
                    if (sf_done_i) begin
`ifdef GRANULE_STATS_EN
                        sf_bits_q[{gr_q, ch_q}] <= cnt_q;
`endif
                        if (w_cnt_lt_len) begin
                            hf_start_q <= 1'b1;
                            state_q    <= S_HF_START;
                        end else begin
                            state_q    <= S_NEXT;
                        end
                    end else if (!w_cnt_lt_len) begin
                        // Budget exhausted before the parser finished: abort slot.
                        err_q   <= 1'b1;
                        state_q <= S_NEXT;
                    end else if (axiiv_i) begin
                        cnt_q <= w_cnt_inc;
                    end
                end

                S_HF_START: begin
                    state_q <= S_HF_RUN;
                end

                S_HF_RUN: begin
                    if (axiiv_i) begin
                        cnt_q <= w_cnt_inc;
                        if (w_cnt_inc == w_len) begin
                            state_q <= S_NEXT;
                        end
                    end
                end

                S_NEXT: begin
                    if (!ch_q && stereo_q) begin
                        ch_q          <= 1'b1;
                        sf_si_valid_q <= (len_q[gr_q][1] != '0);
                        state_q       <= S_LOAD;
                    end else if (gr_q != LAST_GR) begin
                        gr_q          <= w_nxt_gr;
                        ch_q          <= 1'b0;
                        sf_si_valid_q <= (len_q[w_nxt_gr][0] != '0);
                        state_q       <= S_LOAD;
                    end else begin
                        gr_q          <= 1'b0;
                        ch_q          <= 1'b0;
                        frame_done_q  <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_granule_bit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_granule_bit_scheduler
// Description : Directed self-checking bench for granule_bit_scheduler. A
//               small upstream/sf_parser model drives bits and raises sf_done
//               after a per-slot bit count; a monitor tallies the routed bits
//               per slot and the result is compared against hand values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_granule_bit_scheduler;

    localparam int LEN_W = 12;
    localparam int MAXC  = 2000;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       si_valid_i;
    logic                       stereo_i;
    logic [1:0][1:0][LEN_W-1:0] part2_3_length_i;
    logic                       axiid_i;
    logic                       axiiv_i;
    logic                       axiir_o;
    logic                       gr_o;
    logic                       ch_o;
    logic                       sf_si_valid_o;
    logic                       sf_axiid_o;
    logic                       sf_axiiv_o;
    logic                       sf_done_i;
    logic                       hf_start_o;
    logic                       hf_axiid_o;
    logic                       hf_axiiv_o;
    logic                       hf_last_o;
    logic                       frame_done_o;
    logic                       err_o;
`ifdef GRANULE_STATS_EN
    logic [3:0][LEN_W-1:0]      sf_bits_o;
`endif

    granule_bit_scheduler #(.LEN_W(LEN_W), .NGR(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .si_valid_i       (si_valid_i),
        .stereo_i         (stereo_i),
        .part2_3_length_i (part2_3_length_i),
        .axiid_i          (axiid_i),
        .axiiv_i          (axiiv_i),
        .axiir_o          (axiir_o),
        .gr_o             (gr_o),
        .ch_o             (ch_o),
        .sf_si_valid_o    (sf_si_valid_o),
        .sf_axiid_o       (sf_axiid_o),
        .sf_axiiv_o       (sf_axiiv_o),
        .sf_done_i        (sf_done_i),
        .hf_start_o       (hf_start_o),
        .hf_axiid_o       (hf_axiid_o),
        .hf_axiiv_o       (hf_axiiv_o),
        .hf_last_o        (hf_last_o),
        .frame_done_o     (frame_done_o),
        .err_o            (err_o)
`ifdef GRANULE_STATS_EN
        ,
        .sf_bits_o        (sf_bits_o)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Per-frame observations, indexed by slot {gr,ch}.
    int m_sf[4];
    int m_hf[4];
    int m_last_pos[4];
    int m_nlast, m_sfv, m_hfs, m_fd, m_order, m_total, m_route_err;
    int m_first_sfv, m_err_after_sv, m_idle_acc, m_hf_sum;

    // Drives one frame. s* is the sf bit count after which sf_done is
    // raised (-1: never). spur_cyc re-pulses si_valid mid-frame (-1: never).
    // stop_hf returns early once that many hf bits were routed (-1: never).
    task automatic run_frame(input logic st, input int l00, input int l01,
                             input int l10, input int l11, input int s00,
                             input int s01, input int s10, input int s11,
                             input int duty, input int spur_cyc, input int stop_hf);
        int tgt[4];
        int slot_cnt;
        int idx;
        bit done;
        tgt = '{s00, s01, s10, s11};
        for (int i = 0; i < 4; i++) begin
            m_sf[i] = 0; m_hf[i] = 0; m_last_pos[i] = 0;
        end
        m_nlast = 0; m_sfv = 0; m_hfs = 0; m_fd = 0; m_order = 0; m_total = 0;
        m_route_err = 0; m_first_sfv = -1; m_err_after_sv = -1; m_idle_acc = 0;
        m_hf_sum = 0; slot_cnt = 0; done = 1'b0;
        part2_3_length_i[0][0] = LEN_W'(l00);
        part2_3_length_i[0][1] = LEN_W'(l01);
        part2_3_length_i[1][0] = LEN_W'(l10);
        part2_3_length_i[1][1] = LEN_W'(l11);
        stereo_i = st;
        for (int cyc = 0; cyc < MAXC && !done; cyc++) begin
            @(posedge clk); #1;
            si_valid_i = (cyc == 0) || (cyc == spur_cyc);
            axiiv_i    = ((cyc % duty) == 0);
            axiid_i    = m_total[0] ^ m_total[3];
            idx        = {gr_o, ch_o};
            sf_done_i  = (tgt[idx] >= 0) && (slot_cnt == tgt[idx]);
            @(negedge clk);
            idx = {gr_o, ch_o};
            if (cyc == 1) m_err_after_sv = err_o;
            if (sf_si_valid_o) begin
                slot_cnt = 0;
                m_sfv++;
                m_order = m_order * 8 + idx + 1;
                if (m_first_sfv < 0) m_first_sfv = cyc;
            end
            if (hf_start_o) m_hfs++;
            if (frame_done_o) begin
                m_fd++;
                done = 1'b1;
            end
            if (axiiv_i && axiir_o) begin
                if (sf_axiiv_o == hf_axiiv_o) m_route_err++;
                if (sf_axiiv_o) begin
                    if (sf_axiid_o !== axiid_i) m_route_err++;
                    slot_cnt++;
                    m_sf[idx]++;
                end
                if (hf_axiiv_o) begin
                    if (hf_axiid_o !== axiid_i) m_route_err++;
                    m_hf[idx]++;
                    m_hf_sum++;
                    if (hf_last_o) begin
                        m_last_pos[idx] = m_sf[idx] + m_hf[idx];
                        m_nlast++;
                    end
                end
                m_total++;
            end else if (sf_axiiv_o || hf_axiiv_o || hf_last_o) begin
                m_route_err++;
            end
            if (stop_hf >= 0 && m_hf_sum >= stop_hf) return;
        end
        // Idle tail: no bits may be taken and no second frame_done may appear.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            si_valid_i = 1'b0; sf_done_i = 1'b0; axiiv_i = 1'b1;
            @(negedge clk);
            if (axiir_o) m_idle_acc++;
            if (frame_done_o) m_fd++;
        end
        @(posedge clk); #1;
        axiiv_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; si_valid_i = 1'b0; stereo_i = 1'b1; axiid_i = 1'b1; axiiv_i = 1'b1;
        sf_done_i = 1'b1; part2_3_length_i = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (axiir_o !== 1'b0) $display("FAIL reset_axiir got %b want 0", axiir_o); else n_pass++;
        n_total++;
        if ({gr_o, ch_o, sf_si_valid_o, sf_axiid_o, sf_axiiv_o, hf_start_o, hf_axiid_o,
             hf_axiiv_o, hf_last_o, frame_done_o, err_o} !== 11'b0)
            $display("FAIL reset_outputs got %b want 0",
                     {gr_o, ch_o, sf_si_valid_o, sf_axiid_o, sf_axiiv_o, hf_start_o,
                      hf_axiid_o, hf_axiiv_o, hf_last_o, frame_done_o, err_o});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; axiiv_i = 1'b0; sf_done_i = 1'b0; axiid_i = 1'b0;
        @(negedge clk);
        n_total++; if (axiir_o !== 1'b0) $display("FAIL idle_axiir got %b want 0", axiir_o); else n_pass++;
    endtask

    task automatic test_mono(input int duty);
        run_frame(1'b0, 100, 77, 50, 77, 20, 5, 0, 5, duty, -1, -1);
        n_total++; if (m_sf[0] !== 20) $display("FAIL mono_sf00 d%0d got %0d want 20", duty, m_sf[0]); else n_pass++;
        n_total++; if (m_hf[0] !== 80) $display("FAIL mono_hf00 d%0d got %0d want 80", duty, m_hf[0]); else n_pass++;
        n_total++; if (m_sf[2] !== 0) $display("FAIL mono_sf10 d%0d got %0d want 0", duty, m_sf[2]); else n_pass++;
        n_total++; if (m_hf[2] !== 50) $display("FAIL mono_hf10 d%0d got %0d want 50", duty, m_hf[2]); else n_pass++;
        n_total++; if (m_last_pos[0] !== 100 || m_last_pos[2] !== 50 || m_nlast !== 2)
            $display("FAIL mono_hf_last d%0d got %0d/%0d n%0d want 100/50 n2", duty, m_last_pos[0], m_last_pos[2], m_nlast);
        else n_pass++;
        n_total++; if (m_order !== 11) $display("FAIL mono_order d%0d got %0d want 11", duty, m_order); else n_pass++;
        n_total++; if (m_hfs !== 2) $display("FAIL mono_hf_start d%0d got %0d want 2", duty, m_hfs); else n_pass++;
        n_total++; if (m_fd !== 1) $display("FAIL mono_frame_done d%0d got %0d want 1", duty, m_fd); else n_pass++;
        n_total++; if (err_o !== 1'b0) $display("FAIL mono_err d%0d got %b want 0", duty, err_o); else n_pass++;
        n_total++; if (m_total !== 150 || m_route_err !== 0 || m_idle_acc !== 0)
            $display("FAIL mono_stream d%0d got bits %0d rerr %0d idle %0d want 150 0 0", duty, m_total, m_route_err, m_idle_acc);
        else n_pass++;
        n_total++; if (m_first_sfv !== 1) $display("FAIL mono_first_sfv d%0d got %0d want 1", duty, m_first_sfv); else n_pass++;
    endtask

    task automatic test_stereo;
        run_frame(1'b1, 30, 30, 30, 30, 10, 10, 10, 10, 1, -1, -1);
        n_total++; if (m_order !== 668) $display("FAIL stereo_order got %0d want 668", m_order); else n_pass++;
        n_total++; if (m_total !== 120) $display("FAIL stereo_bits got %0d want 120", m_total); else n_pass++;
        n_total++; if (m_sf[3] !== 10 || m_hf[3] !== 20 || m_hf[1] !== 20)
            $display("FAIL stereo_split got sf11 %0d hf11 %0d hf01 %0d want 10 20 20", m_sf[3], m_hf[3], m_hf[1]);
        else n_pass++;
        n_total++; if (m_nlast !== 4 || m_last_pos[1] !== 30) $display("FAIL stereo_hf_last got n%0d pos %0d want n4 pos 30", m_nlast, m_last_pos[1]); else n_pass++;
        n_total++; if (m_fd !== 1 || m_route_err !== 0) $display("FAIL stereo_frame got fd %0d rerr %0d want 1 0", m_fd, m_route_err); else n_pass++;
    endtask

    task automatic test_zero_len;
        run_frame(1'b1, 0, 12, 12, 12, 4, 4, 4, 4, 1, -1, -1);
        n_total++; if (m_sfv !== 3 || m_hfs !== 3) $display("FAIL zero_strobes got sfv %0d hfs %0d want 3 3", m_sfv, m_hfs); else n_pass++;
        n_total++; if (m_order !== 156) $display("FAIL zero_order got %0d want 156", m_order); else n_pass++;
        n_total++; if (m_first_sfv !== 3) $display("FAIL zero_next_load got %0d want 3", m_first_sfv); else n_pass++;
        n_total++; if (m_total !== 36 || m_fd !== 1) $display("FAIL zero_bits got %0d fd %0d want 36 1", m_total, m_fd); else n_pass++;
    endtask

    task automatic test_abort;
        run_frame(1'b0, 40, 0, 10, 0, -1, 0, 3, 0, 1, -1, -1);
        n_total++; if (m_sf[0] !== 40 || m_hf[0] !== 0) $display("FAIL abort_slot got sf %0d hf %0d want 40 0", m_sf[0], m_hf[0]); else n_pass++;
        n_total++; if (m_sf[2] !== 3 || m_hf[2] !== 7 || m_last_pos[2] !== 10)
            $display("FAIL abort_next got sf %0d hf %0d last %0d want 3 7 10", m_sf[2], m_hf[2], m_last_pos[2]);
        else n_pass++;
        n_total++; if (m_hfs !== 1 || m_nlast !== 1) $display("FAIL abort_hf got hfs %0d nlast %0d want 1 1", m_hfs, m_nlast); else n_pass++;
        n_total++; if (err_o !== 1'b1) $display("FAIL abort_err_sticky got %b want 1", err_o); else n_pass++;
        n_total++; if (m_fd !== 1 || m_total !== 50) $display("FAIL abort_frame got fd %0d bits %0d want 1 50", m_fd, m_total); else n_pass++;
    endtask

    task automatic test_sf_done_at_len;
        run_frame(1'b0, 25, 0, 8, 0, 25, 0, 2, 0, 1, -1, -1);
        n_total++; if (m_err_after_sv !== 0) $display("FAIL err_clear_on_si got %0d want 0", m_err_after_sv); else n_pass++;
        n_total++; if (m_sf[0] !== 25 || m_hf[0] !== 0 || m_hfs !== 1)
            $display("FAIL at_len_slot got sf %0d hf %0d hfs %0d want 25 0 1", m_sf[0], m_hf[0], m_hfs);
        else n_pass++;
        n_total++; if (err_o !== 1'b0 || m_total !== 33) $display("FAIL at_len_end got err %b bits %0d want 0 33", err_o, m_total); else n_pass++;
    endtask

    task automatic test_si_valid_busy;
        run_frame(1'b0, 100, 0, 50, 0, 20, 0, 0, 0, 1, 30, -1);
        n_total++; if (err_o !== 1'b1) $display("FAIL busy_si_err got %b want 1", err_o); else n_pass++;
        n_total++; if (m_hf[0] !== 80 || m_hf[2] !== 50 || m_fd !== 1)
            $display("FAIL busy_si_frame got hf %0d/%0d fd %0d want 80/50 1", m_hf[0], m_hf[2], m_fd);
        else n_pass++;
    endtask

    task automatic test_rst_mid;
        int fd_seen;
        run_frame(1'b0, 100, 0, 50, 0, 10, 0, 0, 0, 1, -1, 20);
        @(posedge clk); #1;
        rst = 1'b1; axiiv_i = 1'b1; sf_done_i = 1'b0; si_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (axiir_o !== 1'b0 || hf_axiiv_o !== 1'b0 || {gr_o, ch_o, err_o, frame_done_o} !== 4'b0)
            $display("FAIL rst_mid_idle got axiir %b hfv %b misc %b want 0 0 0000", axiir_o, hf_axiiv_o, {gr_o, ch_o, err_o, frame_done_o});
        else n_pass++;
        fd_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (frame_done_o || axiir_o) fd_seen++;
        end
        n_total++; if (fd_seen !== 0) $display("FAIL rst_mid_quiet got %0d want 0", fd_seen); else n_pass++;
        axiiv_i = 1'b0;
        run_frame(1'b0, 100, 0, 50, 0, 20, 0, 0, 0, 1, -1, -1);
        n_total++; if (m_sf[0] !== 20 || m_hf[0] !== 80 || m_hf[2] !== 50 || m_fd !== 1 || err_o !== 1'b0)
            $display("FAIL rst_mid_clean got sf %0d hf %0d/%0d fd %0d err %b want 20 80/50 1 0", m_sf[0], m_hf[0], m_hf[2], m_fd, err_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mono(1);
        test_stereo();
        test_zero_len();
        test_abort();
        test_sf_done_at_len();
        test_mono(5);
        test_si_valid_busy();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
